// File: rtl/usb_bit_timer.sv
// Bit-period timer for USB receive: sample/shift strobes from a programmable period,
// phase realignment on data edges, and bit position tracking within a word.
module usb_bit_timer #(
    parameter int CNT_W         = 5,
    parameter int START_ON_EDGE = 1,
    parameter int BITS_PER_WORD = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              en,
    input  logic [CNT_W-1:0]                  period,
    input  logic [CNT_W-1:0]                  sample_pt,
    input  logic                              edge_in,
    output logic                              sample_strobe,
    output logic                              shift_strobe,
    output logic                              byte_done,
    output logic                              slip,
    output logic [$clog2(BITS_PER_WORD)-1:0]  bit_idx,
    output logic                              running
);

    localparam int IDX_W = $clog2(BITS_PER_WORD);

    typedef enum logic [1:0] {IDLE, WAIT_EDGE, RUN} state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] per_q;
    logic [CNT_W-1:0] sp_q;
    logic [CNT_W-1:0] per_eff;
    logic [CNT_W-1:0] sp_eff;
    logic             active;
    logic             at_per;
    logic             early;
    logic             late;

    // A zero period degenerates to 2 clocks/bit; an out-of-range sample point falls back to mid-bit.
    assign per_eff = (per_q == '0) ? CNT_W'(1) : per_q;
    assign sp_eff  = (sp_q == '0 || sp_q >= per_eff) ? (per_eff >> 1) : sp_q;

    assign active = (state == RUN) && en && !rst;
    assign at_per = (count == per_eff);
    assign early  = edge_in && (count != '0) && (count >= sp_eff) && (count < per_eff);
    assign late   = edge_in && (count != '0) && (count < sp_eff);

    assign sample_strobe = active && (count == sp_eff);
    assign shift_strobe  = active && (at_per || early);
    assign slip          = active && (early || late);
    assign byte_done     = shift_strobe && (bit_idx == IDX_W'(BITS_PER_WORD - 1));
    assign running       = (state == RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            bit_idx <= '0;
            per_q   <= '0;
            sp_q    <= '0;
        end else begin
            if (state == IDLE) begin
                per_q <= period;
                sp_q  <= sample_pt;
            end
            if (!en) begin
                state   <= IDLE;
                count   <= '0;
                bit_idx <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        count   <= '0;
                        bit_idx <= '0;
                        state   <= (START_ON_EDGE != 0) ? WAIT_EDGE : RUN;
                    end
                    WAIT_EDGE: begin
                        count <= '0;
                        if (edge_in) begin
                            state <= RUN;
                            count <= CNT_W'(1);
                        end
                    end
                    RUN: begin
                        // Any edge off phase 0 restarts the bit with the edge cycle as phase 0.
                        if (edge_in && count != '0)
                            count <= CNT_W'(1);
                        else if (at_per)
                            count <= '0;
                        else
                            count <= count + CNT_W'(1);
                        if (shift_strobe)
                            bit_idx <= bit_idx + IDX_W'(1);
                    end
                    default: begin
                        state <= IDLE;
                        count <= '0;
                    end
                endcase
            end
        end
    end

endmodule
